// File: rtl/sift_pkg.sv
// Shared SIFT-core definitions: image geometry, derived counter widths,
// the loader state encoding and the image-memory write record.
package sift_pkg;

    localparam int IMG_COLS   = 640;
    localparam int IMG_ROWS   = 480;
    localparam int PIX_W      = 8;
    localparam int ROW_W      = 9;
    localparam int WORD_W     = 9;
    localparam int BEAT_CNT_W = 18;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DRAIN,
        LD_DONE
    } loader_state_e;

    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [WORD_W-1:0]  word;
        logic [2*PIX_W-1:0] data;
    } img_wr_t;

endpackage

// File: rtl/img_stream_loader_skid_fifo2.sv
// Two-entry FIFO with the head always in slot0; full/empty come straight
// from the registered count so no consumer-side signal reaches the producer.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign do_push = push && (cnt_q != 2'd2);
    assign do_pop  = pop && (cnt_q != 2'd0);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = push_data;
                else               slot1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                // Head leaves and the new entry lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    slot0_d = push_data;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_data = slot0_q;
    assign full      = (cnt_q == 2'd2);
    assign empty     = (cnt_q == 2'd0);
    assign count     = cnt_q;

endmodule

// File: rtl/img_stream_loader.sv
// Front-end loader: packs the 16-bit pixel-pair stream into row/word writes
// of the original-image memory and pulses frame_done once the frame is stored.
module img_stream_loader #(
    parameter int COLS  = sift_pkg::IMG_COLS,
    parameter int ROWS  = sift_pkg::IMG_ROWS,
    parameter int PIX_W = sift_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [2*PIX_W-1:0] in_data,
    output logic               in_ready,
    output logic               mem_wr_en,
    output logic [8:0]         mem_wr_row,
    output logic [8:0]         mem_wr_word,
    output logic [2*PIX_W-1:0] mem_wr_data,
    input  logic               mem_wr_ready,
    output logic               busy,
    output logic               frame_done
);

    import sift_pkg::*;

    localparam int WORDS = COLS / 2;
    localparam logic [BEAT_CNT_W-1:0] FRAME_BEATS = BEAT_CNT_W'(ROWS * WORDS);
    localparam logic [WORD_W-1:0]     WORD_LAST   = WORD_W'(WORDS - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST    = ROW_W'(ROWS - 1);

    loader_state_e         state_q, state_d;
    logic [BEAT_CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [WORD_W-1:0]     word_q, word_d;

    logic    accept, commit;
    logic    fifo_full, fifo_empty;
    logic [1:0] fifo_count;
    img_wr_t push_entry, head_entry;

    assign in_ready   = (state_q == LD_LOAD) && !fifo_full && (in_cnt_q < FRAME_BEATS);
    assign accept     = in_valid && in_ready;
    assign commit     = !fifo_empty && mem_wr_ready;
    assign push_entry = '{row:  row_q,
                          word: word_q,
                          data: {in_data[PIX_W-1:0], in_data[2*PIX_W-1:PIX_W]}};

    skid_fifo2 #(.W($bits(img_wr_t))) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (commit),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        row_d    = row_q;
        word_d   = word_q;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d  = LD_LOAD;
                    in_cnt_d = '0;
                    row_d    = '0;
                    word_d   = '0;
                end
            end
            LD_LOAD: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (word_q == WORD_LAST) begin
                        word_d = '0;
                        if (row_q != ROW_LAST) row_d = row_q + 1'b1;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                    if (in_cnt_q == FRAME_BEATS - 1'b1) state_d = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                // Enter DONE on the edge of the final commit so frame_done trails it by one cycle.
                if (fifo_empty || (fifo_count == 2'd1 && commit)) state_d = LD_DONE;
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LD_IDLE;
            in_cnt_q <= '0;
            row_q    <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            row_q    <= row_d;
            word_q   <= word_d;
        end
    end

    assign mem_wr_en   = !fifo_empty;
    assign mem_wr_row  = head_entry.row;
    assign mem_wr_word = head_entry.word;
    assign mem_wr_data = head_entry.data;
    assign busy        = (state_q == LD_LOAD) || (state_q == LD_DRAIN);
    assign frame_done  = (state_q == LD_DONE);

endmodule

// File: tb/tb_img_stream_loader.sv
// Scoreboard bench for img_stream_loader on a reduced 640x12 frame.
module tb_img_stream_loader;

    import sift_pkg::*;

    localparam int COLS  = 640;
    localparam int ROWS  = 12;
    localparam int WORDS = COLS / 2;
    localparam int FRAME = ROWS * WORDS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        mem_wr_en;
    logic [8:0]  mem_wr_row;
    logic [8:0]  mem_wr_word;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        busy;
    logic        frame_done;

    img_stream_loader #(.COLS(COLS), .ROWS(ROWS), .PIX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_row   (mem_wr_row),
        .mem_wr_word  (mem_wr_word),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    img_wr_t     exp_q[$];
    logic [15:0] mem [FRAME];
    int sb_beats = 0;
    int frame_commits = 0;
    int total_commits = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_commit_cyc = -10;
    int last_row = -1;
    int last_word = -1;
    int drv_k = 0;
    logic    prev_stall = 1'b0;
    img_wr_t prev_out;

    function automatic logic [15:0] beat_data(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {b, b + 8'd1};
    endfunction

    // Monitor: pushes expected writes on accepted beats, pops on commits.
    always @(negedge clk) begin
        img_wr_t e;
        img_wr_t act;
        int idx;
        cyc++;
        if (rst) begin
            exp_q.delete();
            sb_beats      = 0;
            frame_commits = 0;
            prev_stall    = 1'b0;
        end else begin
            act = '{row: mem_wr_row, word: mem_wr_word, data: mem_wr_data};
            if (prev_stall) begin
                checks++;
                if (mem_wr_en !== 1'b1 || act !== prev_out) begin
                    errors++;
                    $display("[TB] FAIL hold_stable: got en=%b %h, expected en=1 %h", mem_wr_en, act, prev_out);
                end
            end
            if (in_ready === 1'b1) begin
                checks++;
                if (exp_q.size() >= 2) begin
                    errors++;
                    $display("[TB] FAIL ready_when_full: in_ready=1 with fifo occupancy %0d, expected occupancy < 2", exp_q.size());
                end
            end
            if (mem_wr_en === 1'b1 && mem_wr_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got row=%0d word=%0d data=%h, expected no write", mem_wr_row, mem_wr_word, mem_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("[TB] FAIL write_order: got row=%0d word=%0d data=%h, expected row=%0d word=%0d data=%h",
                                 act.row, act.word, act.data, e.row, e.word, e.data);
                    end
                    idx = int'(mem_wr_row) * WORDS + int'(mem_wr_word);
                    if (idx < FRAME) mem[idx] = mem_wr_data;
                    frame_commits++;
                    total_commits++;
                    last_commit_cyc = cyc;
                    last_row  = int'(mem_wr_row);
                    last_word = int'(mem_wr_word);
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                e.row  = 9'(sb_beats / WORDS);
                e.word = 9'(sb_beats % WORDS);
                e.data = {in_data[7:0], in_data[15:8]};
                exp_q.push_back(e);
                sb_beats++;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (frame_commits != FRAME || cyc != last_commit_cyc + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL frame_done_timing: got commits=%0d gap=%0d busy=%b, expected commits=%0d gap=1 busy=0",
                             frame_commits, cyc - last_commit_cyc, busy, FRAME);
                end
            end
            prev_stall = (mem_wr_en === 1'b1) && (mem_wr_ready !== 1'b1);
            prev_out   = act;
        end
    end

    task automatic cycle_drive(input int valid_pct, input int ready_pct, output logic accepted);
        in_valid     = ($urandom_range(0, 99) < valid_pct);
        in_data      = beat_data(drv_k);
        mem_wr_ready = ($urandom_range(0, 99) < ready_pct);
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted) drv_k++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_beats(input int target, input int valid_pct, input int ready_pct, output int ncyc);
        logic acc;
        ncyc = 0;
        while (drv_k < target && ncyc < 20000) begin
            cycle_drive(valid_pct, ready_pct, acc);
            ncyc++;
        end
        in_valid = 1'b0;
        if (drv_k < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: got %0d beats, expected %0d", drv_k, target);
        end
    endtask

    task automatic wait_done(input int ready_pct);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < 2000) begin
            in_valid     = 1'b0;
            mem_wr_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt == start_cnt) begin
            errors++;
            $display("[TB] FAIL done_timeout: got no frame_done, expected one within 2000 cycles");
        end
    endtask

    task automatic start_frame();
        drv_k         = 0;
        sb_beats      = 0;
        frame_commits = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({in_ready, mem_wr_en, mem_wr_row, mem_wr_word, mem_wr_data, busy, frame_done} !== '0) begin
            errors++;
            $display("[TB] FAIL %s: got ready=%b en=%b row=%0d word=%0d data=%h busy=%b done=%b, expected all 0",
                     tag, in_ready, mem_wr_en, mem_wr_row, mem_wr_word, mem_wr_data, busy, frame_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_full_frame();
        int n;
        int d0;
        d0 = done_cnt;
        start_frame();
        run_beats(FRAME, 100, 100, n);
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("[TB] FAIL throughput: got %0d cycles, expected %0d", n, FRAME);
        end
        wait_done(100);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("[TB] FAIL done_once: got %0d pulses, expected 1", done_cnt - d0);
        end
        checks++;
        if (mem[0] !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL first_word: got %h, expected 0100", mem[0]);
        end
        checks++;
        if (last_row != ROWS - 1 || last_word != WORDS - 1) begin
            errors++;
            $display("[TB] FAIL last_address: got row=%0d word=%0d, expected row=%0d word=%0d", last_row, last_word, ROWS - 1, WORDS - 1);
        end
    endtask

    task automatic test_byte_swap();
        int n;
        start_frame();
        in_valid = 1'b1; in_data = 16'hA55A; mem_wr_ready = 1'b0;
        @(negedge clk);
        if (in_valid && in_ready) drv_k++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_data !== 16'h5AA5 || mem_wr_row !== 9'd0 || mem_wr_word !== 9'd0) begin
            errors++;
            $display("[TB] FAIL byte_swap_latency: got en=%b data=%h row=%0d word=%0d, expected en=1 data=5aa5 row=0 word=0",
                     mem_wr_en, mem_wr_data, mem_wr_row, mem_wr_word);
        end
        @(posedge clk);
        #1;
        run_beats(FRAME, 100, 100, n);
        wait_done(100);
        checks++;
        if (mem[0] !== 16'h5AA5 || mem[WORDS] !== 16'h4140) begin
            errors++;
            $display("[TB] FAIL row_wrap: got w0=%h r1w0=%h, expected w0=5aa5 r1w0=4140", mem[0], mem[WORDS]);
        end
    endtask

    task automatic test_random_stall();
        int n;
        int bad;
        logic [7:0] b;
        for (int i = 0; i < FRAME; i++) mem[i] = 16'hDEAD;
        start_frame();
        run_beats(FRAME, 70, 50, n);
        wait_done(50);
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            b = i[7:0];
            checks++;
            if (mem[i] !== {b + 8'd1, b}) begin
                errors++;
                bad++;
                if (bad <= 5) $display("[TB] FAIL golden_image[%0d]: got %h, expected %h", i, mem[i], {b + 8'd1, b});
            end
        end
    endtask

    task automatic test_stall_hold();
        int n;
        int acc;
        int ready_high;
        start_frame();
        acc = 0;
        ready_high = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = beat_data(drv_k); mem_wr_ready = 1'b0;
            @(negedge clk);
            if (in_ready) ready_high++;
            if (in_valid && in_ready) begin acc++; drv_k++; end
            @(posedge clk);
            #1;
        end
        checks++;
        if (acc != 2 || ready_high != 2) begin
            errors++;
            $display("[TB] FAIL stall_accepts: got accepts=%0d ready_cycles=%0d, expected 2 and 2", acc, ready_high);
        end
        in_valid = 1'b0; mem_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (i < 2 && (mem_wr_en !== 1'b1 || mem_wr_row !== 9'd0 || mem_wr_word !== 9'(i))) begin
                errors++;
                $display("[TB] FAIL release_order[%0d]: got en=%b row=%0d word=%0d, expected en=1 row=0 word=%0d", i, mem_wr_en, mem_wr_row, mem_wr_word, i);
            end else if (i == 2 && mem_wr_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL release_drained: got en=%b, expected 0", mem_wr_en);
            end
            @(posedge clk);
            #1;
        end
        run_beats(FRAME, 100, 100, n);
        wait_done(100);
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int d0;
        int c0;
        start_frame();
        run_beats(1000, 100, 50, n);
        in_valid = 1'b1; in_data = beat_data(drv_k); mem_wr_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fifo_nonempty: got en=%b, expected 1", mem_wr_en);
        end
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = done_cnt;
        c0 = total_commits;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = beat_data(i); mem_wr_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (total_commits != c0 || done_cnt != d0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet: got writes=%0d done=%0d, expected 0 and 0", total_commits - c0, done_cnt - d0);
        end
        start_frame();
        in_valid = 1'b1; in_data = beat_data(0); mem_wr_ready = 1'b1;
        @(negedge clk);
        if (in_valid && in_ready) drv_k++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_row !== 9'd0 || mem_wr_word !== 9'd0) begin
            errors++;
            $display("[TB] FAIL fresh_frame_start: got en=%b row=%0d word=%0d, expected en=1 row=0 word=0", mem_wr_en, mem_wr_row, mem_wr_word);
        end
        @(posedge clk);
        #1;
        run_beats(FRAME, 100, 100, n);
        wait_done(100);
    endtask

    task automatic test_ignored_inputs();
        int n;
        int d0;
        logic acc;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'h1234; mem_wr_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_ready[%0d]: got %b, expected 0", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        d0 = done_cnt;
        start_frame();
        run_beats(100, 100, 100, n);
        start = 1'b1;
        cycle_drive(100, 100, acc);
        start = 1'b0;
        run_beats(FRAME, 80, 80, n);
        wait_done(100);
        checks++;
        if (done_cnt - d0 != 1 || sb_beats != FRAME || frame_commits != FRAME) begin
            errors++;
            $display("[TB] FAIL start_in_load: got done=%0d beats=%0d commits=%0d, expected 1 %0d %0d",
                     done_cnt - d0, sb_beats, frame_commits, FRAME, FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_byte_swap();
        test_random_stall();
        test_stall_hold();
        test_reset_mid_frame();
        test_ignored_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
